// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART definitions: FSM state encodings, default baud divisor, counter sizing.
// Also intended for the companion receiver so both ends agree on encodings and divisor.
package uart_tx_fifo_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  // 100 MHz core clock, 115200 baud.
  localparam int UART_DEFAULT_CLK_DIV = 868;

  // Counter width for a 0..n-1 counter; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// 8N1-style UART transmitter draining a registered-read FIFO; first start bit 2 cycles after fifo_rd_en.
// Pops only when tx_en && !fifo_empty at IDLE or the last STOP cycle; back-to-back frames add one FETCH cycle.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int CLK_DIV   = UART_DEFAULT_CLK_DIV,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_en,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_rd_data,
  output logic                 fifo_rd_en,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int BAUD_W = cnt_width(CLK_DIV * STOP_BITS);
  localparam int BIT_W  = cnt_width(DATA_BITS);

  localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLK_DIV - 1);
  localparam logic [BAUD_W-1:0] STOP_LAST = BAUD_W'(CLK_DIV * STOP_BITS - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);

  logic [2:0]           state;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_q;
  logic                 baud_tc;
  logic                 stop_last;

  // STOP spans all stop bits in one count, so its terminal value differs from START/DATA.
  assign baud_tc    = (state == ST_STOP) ? (baud_cnt == STOP_LAST) : (baud_cnt == BIT_LAST);
  assign stop_last  = (state == ST_STOP) && (baud_cnt == STOP_LAST);
  assign fifo_rd_en = tx_en && !fifo_empty && ((state == ST_IDLE) || stop_last);
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          tx <= 1'b1;
          if (fifo_rd_en) state <= ST_FETCH;
        end
        // Read data lands this cycle because the FIFO read port is registered.
        ST_FETCH: begin
          shift_q  <= fifo_rd_data;
          baud_cnt <= '0;
          tx       <= 1'b0;
          state    <= ST_START;
        end
        ST_START: begin
          if (baud_tc) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= shift_q[0];
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (baud_tc) begin
            baud_cnt <= '0;
            if (bit_cnt == DATA_LAST) begin
              tx    <= 1'b1;
              state <= ST_STOP;
            end else begin
              shift_q <= shift_q >> 1;
              tx      <= shift_q[1];
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (baud_tc) begin
            baud_cnt <= '0;
            tx_done  <= 1'b1;
            state    <= fifo_rd_en ? ST_FETCH : ST_IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: two instances (8N1 and 7-bit/2-stop) each fed by a registered-read FIFO model.
module tb_uart_tx_fifo;

  localparam int CDIV = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance 1: 8 data bits, 1 stop bit
  logic       tx_en = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_rd_data;
  logic       fifo_rd_en, tx, busy, tx_done;
  logic [7:0] fmem [0:15];
  int         wr_ptr = 0;
  int         rd_ptr = 0;

  // Instance 2: 7 data bits, 2 stop bits
  logic       tx_en2 = 1'b0;
  logic       fifo_empty2;
  logic [6:0] fifo_rd_data2;
  logic       fifo_rd_en2, tx2, busy2, tx_done2;
  logic [6:0] fmem2 [0:15];
  int         wr_ptr2 = 0;
  int         rd_ptr2 = 0;

  int n_checks = 0;
  int n_fail   = 0;

  logic cap_tx   [0:199];
  logic cap_rd   [0:199];
  logic cap_busy [0:199];
  logic cap_done [0:199];
  logic cap_tx2  [0:199];
  logic cap_busy2[0:199];
  logic cap_done2[0:199];

  uart_tx_fifo #(.CLK_DIV(CDIV), .DATA_BITS(8), .STOP_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .fifo_empty(fifo_empty),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en), .tx(tx),
    .busy(busy), .tx_done(tx_done)
  );

  uart_tx_fifo #(.CLK_DIV(CDIV), .DATA_BITS(7), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en2), .fifo_empty(fifo_empty2),
    .fifo_rd_data(fifo_rd_data2), .fifo_rd_en(fifo_rd_en2), .tx(tx2),
    .busy(busy2), .tx_done(tx_done2)
  );

  assign fifo_empty  = (wr_ptr == rd_ptr);
  assign fifo_empty2 = (wr_ptr2 == rd_ptr2);

  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_rd_data <= fmem[rd_ptr % 16];
      rd_ptr <= rd_ptr + 1;
    end
    if (fifo_rd_en2 && !fifo_empty2) begin
      fifo_rd_data2 <= fmem2[rd_ptr2 % 16];
      rd_ptr2 <= rd_ptr2 + 1;
    end
  end

  task automatic push1(input logic [7:0] b);
    fmem[wr_ptr % 16] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic push2(input logic [6:0] b);
    fmem2[wr_ptr2 % 16] = b;
    wr_ptr2 = wr_ptr2 + 1;
  endtask

  // Called at a negedge with inputs applied; slot i is the i-th cycle from now.
  task automatic capture(input int start, input int n);
    for (int i = start; i < start + n; i++) begin
      #1;
      cap_tx[i]    = tx;
      cap_rd[i]    = fifo_rd_en;
      cap_busy[i]  = busy;
      cap_done[i]  = tx_done;
      cap_tx2[i]   = tx2;
      cap_busy2[i] = busy2;
      cap_done2[i] = tx_done2;
      @(negedge clk);
    end
  endtask

  // Expected line level rel cycles after the start bit begins.
  function automatic logic exp_line(input int rel, input logic [7:0] b, input int nbits);
    int bitn;
    if (rel < 0) return 1'b1;
    bitn = rel / CDIV;
    if (bitn == 0) return 1'b0;
    if (bitn <= nbits) return b[bitn-1];
    return 1'b1;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (tx !== 1'b1)      begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx); end
    n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (tx_done !== 1'b0) begin n_fail++; $display("FAIL reset_tx_done: got %b expected 0", tx_done); end
    n_checks++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b expected 0", fifo_rd_en); end
    n_checks++; if (tx2 !== 1'b1)     begin n_fail++; $display("FAIL reset_tx2: got %b expected 1", tx2); end
    n_checks++; if (busy2 !== 1'b0)   begin n_fail++; $display("FAIL reset_busy2: got %b expected 0", busy2); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single;
    int bad; int nrd; int ndone; int fd;
    bad = -1; nrd = 0; ndone = 0; fd = -1;
    tx_en = 1'b1;
    push1(8'hA5);
    capture(0, 46);
    for (int i = 0; i < 46; i++) begin
      if (cap_tx[i] !== exp_line(i - 2, 8'hA5, 8) && bad < 0) bad = i;
      if (cap_rd[i] === 1'b1) nrd++;
      if (cap_done[i] === 1'b1) begin ndone++; if (fd < 0) fd = i; end
    end
    n_checks++; if (cap_rd[0] !== 1'b1) begin n_fail++; $display("FAIL single_rd_en_first: got %b expected 1", cap_rd[0]); end
    n_checks++; if (nrd != 1) begin n_fail++; $display("FAIL single_rd_count: got %0d expected 1", nrd); end
    n_checks++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL single_tx_wave: cycle %0d tx=%b expected %b", bad, cap_tx[bad], exp_line(bad - 2, 8'hA5, 8));
    end
    n_checks++; if (ndone != 1) begin n_fail++; $display("FAIL single_done_count: got %0d expected 1", ndone); end
    n_checks++; if (fd != 42) begin n_fail++; $display("FAIL single_done_cycle: got %0d expected 42", fd); end
    n_checks++; if (cap_busy[1] !== 1'b1) begin n_fail++; $display("FAIL single_busy_fetch: got %b expected 1", cap_busy[1]); end
    n_checks++; if (cap_busy[41] !== 1'b1) begin n_fail++; $display("FAIL single_busy_stop: got %b expected 1", cap_busy[41]); end
    n_checks++; if (cap_busy[42] !== 1'b0) begin n_fail++; $display("FAIL single_busy_idle: got %b expected 0", cap_busy[42]); end
  endtask

  task automatic test_back_to_back;
    int bad; int nrd; int rd_off; int ndone; int done_off; int run; int nbusy_low;
    logic e;
    bad = -1; nrd = 0; rd_off = 0; ndone = 0; done_off = 0; run = 0; nbusy_low = 0;
    push1(8'h00);
    push1(8'hFF);
    push1(8'h55);
    capture(0, 130);
    for (int i = 0; i < 130; i++) begin
      e = exp_line(i - 2, 8'h00, 8) & exp_line(i - 43, 8'hFF, 8) & exp_line(i - 84, 8'h55, 8);
      if (cap_tx[i] !== e && bad < 0) bad = i;
      if (cap_rd[i] === 1'b1) begin nrd++; if (i != 0 && i != 41 && i != 82) rd_off++; end
      if (cap_done[i] === 1'b1) begin ndone++; if (i != 42 && i != 83 && i != 124) done_off++; end
      if (i >= 1 && i <= 123 && cap_busy[i] !== 1'b1) nbusy_low++;
    end
    for (int i = 38; i < 60; i++) begin
      if (cap_tx[i] !== 1'b1) break;
      run++;
    end
    n_checks++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL b2b_tx_wave: cycle %0d tx=%b", bad, cap_tx[bad]);
    end
    n_checks++; if (nrd != 3 || rd_off != 0) begin n_fail++; $display("FAIL b2b_rd_en: got %0d pulses (%0d misplaced) expected 3 at 0/41/82", nrd, rd_off); end
    n_checks++; if (ndone != 3 || done_off != 0) begin n_fail++; $display("FAIL b2b_tx_done: got %0d pulses (%0d misplaced) expected 3 at 42/83/124", ndone, done_off); end
    n_checks++; if (run != 5) begin n_fail++; $display("FAIL b2b_gap_high: got %0d cycles expected 5", run); end
    n_checks++; if (nbusy_low != 0) begin n_fail++; $display("FAIL b2b_busy_hold: got %0d low cycles expected 0", nbusy_low); end
    n_checks++; if (cap_busy[124] !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_end: got %b expected 0", cap_busy[124]); end
  endtask

  task automatic test_hold_and_drop;
    int nrd; int nhigh_bad; int nbusy; int bad; int first_low; int ndone; int fd;
    nrd = 0; nhigh_bad = 0; nbusy = 0; bad = -1; first_low = -1; ndone = 0; fd = -1;
    tx_en = 1'b0;
    push1(8'h3C);
    push1(8'h81);
    capture(0, 10);
    for (int i = 0; i < 10; i++) begin
      if (cap_rd[i] === 1'b1) nrd++;
      if (cap_tx[i] !== 1'b1) nhigh_bad++;
      if (cap_busy[i] !== 1'b0) nbusy++;
    end
    n_checks++; if (nrd != 0) begin n_fail++; $display("FAIL hold_rd_en: got %0d pulses expected 0", nrd); end
    n_checks++; if (nhigh_bad != 0) begin n_fail++; $display("FAIL hold_tx_idle: got %0d non-high cycles expected 0", nhigh_bad); end
    n_checks++; if (nbusy != 0) begin n_fail++; $display("FAIL hold_busy: got %0d busy cycles expected 0", nbusy); end

    tx_en = 1'b1;
    capture(0, 20);
    tx_en = 1'b0;       // now inside data bit 3 of the 0x3C frame
    capture(20, 30);
    nrd = 0;
    for (int i = 0; i < 50; i++) begin
      if (cap_tx[i] !== exp_line(i - 2, 8'h3C, 8) && bad < 0) bad = i;
      if (cap_tx[i] === 1'b0 && first_low < 0) first_low = i;
      if (cap_rd[i] === 1'b1) nrd++;
      if (cap_done[i] === 1'b1) begin ndone++; if (fd < 0) fd = i; end
    end
    n_checks++; if (cap_rd[0] !== 1'b1) begin n_fail++; $display("FAIL drop_rd_en_same_cycle: got %b expected 1", cap_rd[0]); end
    n_checks++; if (first_low != 2) begin n_fail++; $display("FAIL drop_start_latency: got %0d expected 2", first_low); end
    n_checks++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL drop_tx_wave: cycle %0d tx=%b expected %b", bad, cap_tx[bad], exp_line(bad - 2, 8'h3C, 8));
    end
    n_checks++; if (nrd != 1) begin n_fail++; $display("FAIL drop_rd_count: got %0d expected 1", nrd); end
    n_checks++; if (ndone != 1 || fd != 42) begin n_fail++; $display("FAIL drop_tx_done: got %0d pulses first at %0d expected 1 at 42", ndone, fd); end
    n_checks++; if (cap_busy[49] !== 1'b0) begin n_fail++; $display("FAIL drop_idle: got busy %b expected 0", cap_busy[49]); end
    n_checks++; if (wr_ptr - rd_ptr != 1) begin n_fail++; $display("FAIL drop_fifo_left: got %0d entries expected 1", wr_ptr - rd_ptr); end
  endtask

  task automatic test_reset_mid_frame;
    int ndone; int bad; int fd;
    ndone = 0; bad = -1; fd = -1;
    tx_en = 1'b1;
    capture(0, 13);
    n_checks++; if (cap_tx[12] !== 1'b0) begin n_fail++; $display("FAIL rst_pre_bit: got %b expected 0", cap_tx[12]); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (tx !== 1'b1)   begin n_fail++; $display("FAIL rst_mid_tx: got %b expected 1", tx); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    for (int i = 0; i < 3; i++) begin
      if (tx_done === 1'b1) ndone++;
      @(negedge clk);
      #1;
    end
    n_checks++; if (ndone != 0) begin n_fail++; $display("FAIL rst_mid_done: got %0d pulses expected 0", ndone); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push1(8'h96);
    capture(0, 46);
    ndone = 0;
    for (int i = 0; i < 46; i++) begin
      if (cap_tx[i] !== exp_line(i - 2, 8'h96, 8) && bad < 0) bad = i;
      if (cap_done[i] === 1'b1) begin ndone++; if (fd < 0) fd = i; end
    end
    n_checks++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL rst_after_tx_wave: cycle %0d tx=%b expected %b", bad, cap_tx[bad], exp_line(bad - 2, 8'h96, 8));
    end
    n_checks++; if (ndone != 1 || fd != 42) begin n_fail++; $display("FAIL rst_after_done: got %0d pulses first at %0d expected 1 at 42", ndone, fd); end
  endtask

  task automatic test_seven_bit_two_stop;
    int bad; int ndone; int fd;
    bad = -1; ndone = 0; fd = -1;
    tx_en2 = 1'b1;
    push2(7'h41);
    capture(0, 46);
    for (int i = 0; i < 46; i++) begin
      if (cap_tx2[i] !== exp_line(i - 2, 8'h41, 7) && bad < 0) bad = i;
      if (cap_done2[i] === 1'b1) begin ndone++; if (fd < 0) fd = i; end
    end
    n_checks++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL d7s2_tx_wave: cycle %0d tx=%b expected %b", bad, cap_tx2[bad], exp_line(bad - 2, 8'h41, 7));
    end
    n_checks++; if (ndone != 1 || fd != 42) begin n_fail++; $display("FAIL d7s2_done: got %0d pulses first at %0d expected 1 at 42", ndone, fd); end
    n_checks++; if (cap_busy2[41] !== 1'b1 || cap_busy2[42] !== 1'b0) begin n_fail++; $display("FAIL d7s2_stop_len: busy at 41/42 got %b/%b expected 1/0", cap_busy2[41], cap_busy2[42]); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_hold_and_drop();
    test_reset_mid_frame();
    test_seven_bit_two_stop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
